// File: rtl/output_port_sched.sv
// Wormhole output-port scheduler: round-robin arbitration over L,N,S,W inputs, packet lock
// from head to tail, credit-gated transfers. Optional stall counter under `SCHED_STALL_CNT_EN`.
module output_port_sched #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATASIZE-1:0] data_in,
  input  logic                  credit_ret,
  output logic [3:0]            grant,
  output logic [DATASIZE-1:0]   data_out,
  output logic                  data_valid,
  output logic [WIDTH:0]        credits,
  output logic                  locked,
  output logic [15:0]           stall_cnt
);

  localparam logic [1:0]     T_SINGLE  = 2'b00;
  localparam logic [1:0]     T_HEAD    = 2'b01;
  localparam logic [1:0]     T_BODY    = 2'b10;
  localparam logic [1:0]     T_TAIL    = 2'b11;
  localparam logic [WIDTH:0] MAX_CRED  = (WIDTH+1)'(DEPTH);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t          state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [WIDTH:0]       credits_q;
  logic [3:0]           eligible;
  logic [1:0]           winner;
  logic                 found;
  logic                 xfer;
  logic [DATASIZE-1:0]  win_flit;
  logic [DATASIZE-1:0]  fwd_flit;
  logic [DATASIZE-1:0]  data_p1;
  logic                 vld_p1;

  // Saturating credit update; a return and a consume in the same cycle cancel out.
  function automatic logic [WIDTH:0] credit_next(input logic [WIDTH:0] cur,
                                                 input logic take, input logic give);
    if (take && !give)
      return cur - (WIDTH+1)'(1);
    if (give && !take && cur < MAX_CRED)
      return cur + (WIDTH+1)'(1);
    return cur;
  endfunction

  always_comb begin
    eligible = (state_q == LOCKED) ? (req & (4'b0001 << owner_q)) : req;
  end

  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && eligible[ptr_q + 2'(k)]) begin
        found  = 1'b1;
        winner = ptr_q + 2'(k);
      end
    end
    xfer     = found && (credits_q != '0) && !rst;
    grant    = xfer ? (4'b0001 << winner) : 4'b0000;
    win_flit = data_in[winner*DATASIZE +: DATASIZE];
  end

  // Lock FSM; stray body/tail while unlocked go out as singles, stray heads while locked as bodies.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    fwd_flit = win_flit;
    if (xfer) begin
      case (state_q)
        UNLOCKED: begin
          if (win_flit[1:0] == T_HEAD) begin
            state_d = LOCKED;
            owner_d = winner;
          end else begin
            fwd_flit[1:0] = T_SINGLE;
            ptr_d         = winner + 2'd1;
          end
        end
        LOCKED: begin
          if (win_flit[1:0] == T_TAIL) begin
            state_d = UNLOCKED;
            ptr_d   = winner + 2'd1;
          end else if (win_flit[1:0] == T_HEAD) begin
            fwd_flit[1:0] = T_BODY;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // Stage p1: registered output flit and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      credits_q <= MAX_CRED;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      credits_q <= credit_next(credits_q, xfer, credit_ret);
      vld_p1    <= xfer;
      if (xfer)
        data_p1 <= fwd_flit;
    end
  end

  assign data_out   = data_p1;
  assign data_valid = vld_p1;
  assign credits    = credits_q;
  assign locked     = (state_q == LOCKED);

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= 16'h0;
    else if (|eligible && credits_q == '0)
      stall_q <= sat_inc16(stall_q);
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_output_port_sched.sv
// Self-checking bench for output_port_sched: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of the scheduler.
module tb_output_port_sched;
  localparam int DEPTH = 8;
  localparam int WIDTH = 3;
  localparam int DW    = 40;
`ifdef SCHED_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] data_in;
  logic            credit_ret;
  logic [3:0]      grant;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic [WIDTH:0]  credits;
  logic            locked;
  logic [15:0]     stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q [4][$];

  output_port_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .credit_ret(credit_ret),
    .grant(grant), .data_out(data_out), .data_valid(data_valid), .credits(credits),
    .locked(locked), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int tag);
    return {6'h2A, 32'(tag), t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int i, input logic [DW-1:0] f);
    data_in[i*DW +: DW] = f;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; credit_ret = 1'b0; data_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; credit_ret = 1'b0;
    for (int i = 0; i < 4; i++) set_flit(i, mk(2'b00, int'($urandom)));
    #1;
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
    tick();
    n_checks++; if (credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits got %0d want 8", credits); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", data_valid); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    rst = 1'b0; req = 4'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) set_flit(i, mk(2'b00, c*16 + i));
      #1;
      exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, grant, exp_g); end
      if (c >= 1) begin
        n_checks++; if (data_valid !== (c <= 8)) begin n_fail++; $display("FAIL rr_valid c=%0d got %b want %b", c, data_valid, c <= 8); end
        if (c <= 8) begin
          n_checks++;
          if (data_out !== mk(2'b00, (c-1)*16 + (c-1)%4)) begin
            n_fail++; $display("FAIL rr_data c=%0d got %h want %h", c, data_out, mk(2'b00, (c-1)*16 + (c-1)%4));
          end
        end
      end
      tick();
    end
    n_checks++; if (credits !== 4'd0) begin n_fail++; $display("FAIL rr_credits got %0d want 0", credits); end
    req = 4'b0;
  endtask

  task automatic test_wormhole();
    logic [1:0] typ [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    do_reset();
    req = 4'b0001; set_flit(0, mk(2'b00, 100));
    #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wh_seed got %b want 0001", grant); end
    tick();
    req = 4'b0111; set_flit(0, mk(2'b00, 101)); set_flit(2, mk(2'b00, 102));
    for (int s = 0; s < 4; s++) begin
      set_flit(1, mk(typ[s], 200 + s));
      #1;
      n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL wh_grant s=%0d got %b want 0010", s, grant); end
      n_checks++; if (locked !== (s != 0)) begin n_fail++; $display("FAIL wh_locked s=%0d got %b want %b", s, locked, s != 0); end
      tick();
      n_checks++; if (data_out !== mk(typ[s], 200 + s)) begin n_fail++; $display("FAIL wh_data s=%0d got %h want %h", s, data_out, mk(typ[s], 200 + s)); end
    end
    req = 4'b0101;
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL wh_unlock got %b want 0", locked); end
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL wh_next got %b want 0100", grant); end
    tick();
    req = 4'b0001;
    #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wh_last got %b want 0001", grant); end
    tick();
    n_checks++; if (data_out !== mk(2'b00, 101)) begin n_fail++; $display("FAIL wh_ldata got %h want %h", data_out, mk(2'b00, 101)); end
    req = 4'b0;
  endtask

  task automatic test_bubble();
    do_reset();
    req = 4'b1000; set_flit(3, mk(2'b01, 300));
    #1;
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL bub_head got %b want 1000", grant); end
    tick();
    req = 4'b1001; set_flit(3, mk(2'b10, 301)); set_flit(0, mk(2'b00, 400));
    #1;
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL bub_body got %b want 1000", grant); end
    tick();
    req = 4'b0001;
    for (int b = 0; b < 2; b++) begin
      #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL bub_gap b=%0d got %b want 0000", b, grant); end
      tick();
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL bub_valid b=%0d got %b want 0", b, data_valid); end
    end
    req = 4'b1001; set_flit(3, mk(2'b11, 302));
    #1;
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL bub_tail got %b want 1000", grant); end
    tick();
    req = 4'b0001;
    #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL bub_after got %b want 0001", grant); end
    tick();
    n_checks++; if (data_out !== mk(2'b00, 400)) begin n_fail++; $display("FAIL bub_data got %h want %h", data_out, mk(2'b00, 400)); end
    req = 4'b0;
  endtask

  task automatic test_credit_return();
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      set_flit(0, mk(2'b00, 500 + k));
      tick();
    end
    n_checks++; if (credits !== 4'd0) begin n_fail++; $display("FAIL cr_drain got %0d want 0", credits); end
    credit_ret = 1'b1;
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL cr_same got %b want 0000", grant); end
    tick();
    credit_ret = 1'b0;
    n_checks++; if (credits !== 4'd1) begin n_fail++; $display("FAIL cr_one got %0d want 1", credits); end
    #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL cr_next got %b want 0001", grant); end
    tick();
    n_checks++; if (credits !== 4'd0) begin n_fail++; $display("FAIL cr_zero got %0d want 0", credits); end
    req = 4'b0;
  endtask

  task automatic test_credit_sat();
    do_reset();
    credit_ret = 1'b1;
    tick();
    n_checks++; if (credits !== 4'd8) begin n_fail++; $display("FAIL sat_max got %0d want 8", credits); end
    credit_ret = 1'b0; req = 4'b0001; set_flit(0, mk(2'b00, 600));
    tick(); tick(); tick();
    n_checks++; if (credits !== 4'd5) begin n_fail++; $display("FAIL sat_five got %0d want 5", credits); end
    credit_ret = 1'b1;
    #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL sat_grant got %b want 0001", grant); end
    tick();
    n_checks++; if (credits !== 4'd5) begin n_fail++; $display("FAIL sat_both got %0d want 5", credits); end
    credit_ret = 1'b0; req = 4'b0;
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    req = 4'b0100; set_flit(2, mk(2'b00, 700));
    for (int k = 0; k < 8; k++) tick();
    n_checks++; if (credits !== 4'd0) begin n_fail++; $display("FAIL st_drain got %0d want 0", credits); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL st_pre got %0d want 0", stall_cnt); end
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (stall_cnt !== (STALL_EN ? 16'd20 : 16'd0)) begin
      n_fail++; $display("FAIL st_count got %0d want %0d", stall_cnt, STALL_EN ? 20 : 0);
    end
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0; set_flit(2, mk(2'b01, 701));
    #1;
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL st_head got %b want 0100", grant); end
    tick();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL st_locked got %b want 1", locked); end
    rst = 1'b1; set_flit(2, mk(2'b10, 702));
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL st_rstgrant got %b want 0000", grant); end
    tick();
    rst = 1'b0; req = 4'b0;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL st_rstlock got %b want 0", locked); end
    n_checks++; if (credits !== 4'd8) begin n_fail++; $display("FAIL st_rstcred got %0d want 8", credits); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL st_rststall got %0d want 0", stall_cnt); end
  endtask

  task automatic refill(input int i, inout int tag);
    int nb;
    if ($urandom % 10 == 0) begin
      q[i].push_back(mk(2'($urandom), tag)); tag++;
    end else if ($urandom % 2 == 0) begin
      q[i].push_back(mk(2'b00, tag)); tag++;
    end else begin
      nb = int'($urandom % 3);
      q[i].push_back(mk(2'b01, tag)); tag++;
      for (int b = 0; b < nb; b++) begin q[i].push_back(mk(2'b10, tag)); tag++; end
      q[i].push_back(mk(2'b11, tag)); tag++;
    end
  endtask

  task automatic test_random();
    int m_credits, m_ptr, m_owner, m_stall, win, tag, idx;
    bit m_locked, m_dv;
    logic [DW-1:0] m_do, f;
    logic [3:0] elig, exp_g;
    do_reset();
    m_credits = DEPTH; m_ptr = 0; m_owner = 0; m_stall = 0;
    m_locked = 1'b0; m_dv = 1'b0; m_do = '0; tag = 1000;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() == 0 && $urandom % 3 == 0) refill(i, tag);
        req[i] = (q[i].size() != 0) && ($urandom % 4 != 0);
        set_flit(i, (q[i].size() != 0) ? q[i][0] : mk(2'($urandom), int'($urandom)));
      end
      credit_ret = ($urandom % 3 == 0);
      #1;
      elig = m_locked ? (req & 4'(1 << m_owner)) : req;
      exp_g = 4'b0; win = -1;
      if (m_credits != 0) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (win < 0 && elig[idx]) begin win = idx; exp_g = 4'(1 << idx); end
        end
      end
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rnd_grant c=%0d got %b want %b", c, grant, exp_g); end
      if (STALL_EN && elig != 0 && m_credits == 0 && m_stall < 65535) m_stall++;
      if (win >= 0) begin
        f = q[win].pop_front();
        if (!m_locked) begin
          if (f[1:0] == 2'b01) begin m_locked = 1'b1; m_owner = win; end
          else begin f[1:0] = 2'b00; m_ptr = (win + 1) % 4; end
        end else begin
          if (f[1:0] == 2'b11) begin m_locked = 1'b0; m_ptr = (win + 1) % 4; end
          else if (f[1:0] == 2'b01) f[1:0] = 2'b10;
        end
        m_do = f;
        if (!credit_ret) m_credits--;
      end else if (credit_ret && m_credits < DEPTH) begin
        m_credits++;
      end
      m_dv = (win >= 0);
      tick();
      n_checks++; if (data_valid !== m_dv) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, data_valid, m_dv); end
      n_checks++; if (data_out !== m_do) begin n_fail++; $display("FAIL rnd_data c=%0d got %h want %h", c, data_out, m_do); end
      n_checks++; if (credits !== (WIDTH+1)'(m_credits)) begin n_fail++; $display("FAIL rnd_credits c=%0d got %0d want %0d", c, credits, m_credits); end
      n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL rnd_locked c=%0d got %b want %b", c, locked, m_locked); end
      n_checks++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall c=%0d got %0d want %0d", c, stall_cnt, m_stall); end
    end
    req = 4'b0; credit_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; credit_ret = 1'b0; data_in = '0;
    tick();
    test_reset();
    test_round_robin();
    test_wormhole();
    test_bubble();
    test_credit_return();
    test_credit_sat();
    test_stall_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
